// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: control inputs from decode, the instruction
// memory port, the IF/ID pipeline register and the performance counters.
// The master side is the fetch unit; the slave side is the environment
// (memory, decoder, hazard logic).
interface fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, halt_req, resume, imem_data,
        output imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid,
               halted, fetch_count, stall_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, halt_req, resume, imem_data,
        input  imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid,
               halted, fetch_count, stall_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 16-bit RISC core.
// Owns the PC, addresses the instruction memory combinationally and latches
// the returned word into the IF/ID register. Control priority in RUN is
// redirect > halt_req > stall > advance.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is
// defined; otherwise fetch_count/stall_count read as zero.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // PC is always halfword aligned, including the reset value.
    localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic [15:0] plus2_q, plus2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] target_pc;

    assign target_pc = bus.redirect_pc & 16'hFFFE;

    // Next-state and next-pipeline-register computation for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        plus2_d   = plus2_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        case (state_q)
            BOOT: begin
                // One settling cycle: memory sees the reset PC, nothing issues.
                valid_d = 1'b0;
                state_d = RUN;
                if (bus.redirect_valid) begin
                    pc_d = target_pc;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // Drop the wrong-path word; stall is irrelevant here.
                    pc_d    = target_pc;
                    valid_d = 1'b0;
                end else if (bus.halt_req || !bus.stall) begin
                    // halt_req still issues the word currently being fetched.
                    instr_d   = bus.imem_data;
                    ifid_pc_d = pc_q;
                    plus2_d   = pc_q + 16'd2;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                    if (bus.halt_req) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    pc_d     = target_pc;
                    state_d  = RUN;
                    halted_d = 1'b0;
                end else if (bus.resume) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // FSM state, PC and IF/ID register; reset overrides every control input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= 16'h0000;
            ifid_pc_q <= 16'h0000;
            plus2_q   <= 16'h0000;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            plus2_q   <= plus2_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_pc_plus2 = plus2_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.halted        = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        run_no_redirect;

    assign run_no_redirect = (state_q == RUN) && !bus.redirect_valid;

    // Count issued instructions and genuine stall cycles; both wrap freely.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (run_no_redirect && (bus.halt_req || !bus.stall)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (run_no_redirect && !bus.halt_req && bus.stall) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.fetch_count = 16'h0000;
    assign bus.stall_count = 16'h0000;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit RISC core, directly upstream of the instruction memory.
- Owns the program counter and drives the memory's byte address; word select is pc[8:1] (256 x 16-bit words).
- Captures the returned instruction into the IF/ID pipeline register for the decoder/control unit.
- Accepts stall, redirect (branch/jump target resolved downstream) and halt/resume controls.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 is ignored (forced 0).
- PC_STEP, 2, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard hold from decode; freezes PC and IF/ID
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  16  redirect target byte address
- halt_req  input  1  enter HALT after the current fetch
- resume  input  1  leave HALT
- imem_addr  output  16  byte address to the instruction memory (equals pc)
- imem_data  input  16  instruction word returned combinationally for imem_addr
- ifid_instr  output  16  latched instruction
- ifid_pc  output  16  address of ifid_instr
- ifid_pc_plus2  output  16  ifid_pc + 2 (mod 2^16)
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- halted  output  1  high while in HALT
- fetch_count  output  16  instructions issued (optional feature)
- stall_count  output  16  stall cycles seen (optional feature)

Behaviour:
- Reset (rst=1 at an edge, any state): pc=RESET_PC&~1, ifid_instr=0, ifid_pc=0, ifid_pc_plus2=0, ifid_valid=0, halted=0, counters=0, state=BOOT.
- imem_addr = pc, combinational. The instruction is latched at the same edge that advances pc, giving 1-cycle fetch latency.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts one cycle. ifid_valid stays 0, pc holds. Then -> RUN. Redirect in BOOT loads the target pc, still -> RUN.
- RUN, per edge, with priority redirect > halt_req > stall > advance:
  - redirect_valid: pc=redirect_pc&~1; ifid_valid=0 (flushes the wrong-path instruction); stall ignored.
  - halt_req: latch imem_data as a normal advance, then -> HALT.
  - stall: pc and all ifid_* hold.
  - otherwise: ifid_instr=imem_data, ifid_pc=pc, ifid_pc_plus2=pc+2, ifid_valid=1, pc=pc+PC_STEP.
- HALT: halted=1, pc holds, ifid_valid=0 after the first HALT edge.
  - resume -> RUN; the next fetch starts at the held pc.
  - redirect_valid -> pc=target and -> RUN.
  - Simultaneous resume and redirect: redirect target is used.
- Wrap-around: pc+2 wraps 16'hFFFE -> 16'h0000 with no flag. Aliasing above 512 bytes is the memory's concern.
- Redirect with odd target: bit 0 silently cleared.
- Stall on the same cycle as halt_req: halt_req wins, and the instruction is latched.
- rst mid-stall, mid-redirect or in HALT: reset values win unconditionally.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments on every RUN advance (ifid_valid set by an advance).
  - stall_count increments on every RUN cycle with stall=1 and no redirect/halt_req.
  - Both wrap at 16'hFFFF -> 0 and clear on rst.
- Undefined: both outputs tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset then 4 free-running cycles, RESET_PC=0, memory word0=16'h1000, word1=16'h1442 -> BOOT cycle ifid_valid=0; next edges give ifid_pc=0, instr=16'h1000, then ifid_pc=2, instr=16'h1442; imem_addr=4 after the second advance.
- Stall held 3 cycles at pc=6 -> pc and ifid_* frozen for 3 cycles, resumes at ifid_pc=6; stall_count=3 with FETCH_PERF_CNT_EN.
- Redirect to 16'h0019 while stall=1 at pc=10 -> next cycle ifid_valid=0, imem_addr=16'h0018; following edge ifid_pc=16'h0018.
- halt_req at pc=8 -> ifid_pc=8 latched, halted=1, pc holds 10 for 5 cycles; resume -> next ifid_pc=10, halted=0.
- Free-run from RESET_PC=16'hFFFC -> ifid_pc sequence FFFC, FFFE, 0000; ifid_pc_plus2 for FFFE is 0000.
- rst asserted while in HALT with pending redirect -> pc=RESET_PC, ifid_valid=0, halted=0, state BOOT; fetch_count=0.
